// File: rtl/drac_pkg.sv
// Shared vector-pipeline types and constants, including the banked vector regfile geometry.
package drac_pkg;

    localparam int NUM_SIMD_WB             = 2;
    localparam int NUM_PHISICAL_VREGISTERS = 64;
    localparam int VLEN                    = 128;
    localparam int VRF_NUM_BANKS           = 4;

    typedef logic [$clog2(NUM_PHISICAL_VREGISTERS)-1:0] phvreg_t;
    typedef logic [VLEN-1:0]                            bus_simd_t;
    typedef logic [$clog2(VRF_NUM_BANKS)-1:0]           vrf_bank_t;

    // Bank index of a physical vector register: low address bits.
    function automatic vrf_bank_t vrf_bank_of(input phvreg_t addr);
        return addr[$clog2(VRF_NUM_BANKS)-1:0];
    endfunction

endpackage

// File: rtl/vrf_bank_arbiter.sv
// Per-bank read arbiter: picks one distinct address per cycle with a round-robin pointer,
// grants every port asking for that address, and flags denied requesters.
module vrf_bank_arbiter
    import drac_pkg::*;
#(
    parameter int NUM_RD    = 3,
    parameter int NUM_BANKS = VRF_NUM_BANKS,
    parameter int AW        = $clog2(NUM_PHISICAL_VREGISTERS),
    parameter int BANK_IDX  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [NUM_RD-1:0]    req_i,
    input  logic [NUM_RD*AW-1:0] addr_i,
    output logic [NUM_RD-1:0]    gnt_o,
    output logic [AW-1:0]        win_addr_o,
    output logic                 conflict_o
);

    localparam int BW  = $clog2(NUM_BANKS);
    localparam int RRW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

    logic [RRW-1:0]    rr_q;
    logic [RRW-1:0]    rr_d;
    logic [RRW-1:0]    win_idx;
    logic [NUM_RD-1:0] match;
    logic [NUM_RD-1:0] grant;
    logic              found;
    logic              conflict;
    logic              kill;
    int                cand;

    always_comb begin
        match      = '0;
        grant      = '0;
        found      = 1'b0;
        win_idx    = '0;
        win_addr_o = '0;
        cand       = 0;
        for (int p = 0; p < NUM_RD; p++) begin
            match[p] = req_i[p] && (addr_i[p*AW +: BW] == BW'(BANK_IDX));
        end
        // Scan ports starting at the round-robin pointer, wrapping modulo NUM_RD.
        for (int k = 0; k < NUM_RD; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NUM_RD) begin
                cand = cand - NUM_RD;
            end
            if (!found && match[cand]) begin
                found      = 1'b1;
                win_idx    = RRW'(cand);
                win_addr_o = addr_i[cand*AW +: AW];
            end
        end
        for (int p = 0; p < NUM_RD; p++) begin
            grant[p] = found && match[p] && (addr_i[p*AW +: AW] == win_addr_o);
        end
        conflict = |(match & ~grant);
    end

    // Flush and reset suppress arbitration entirely, so the pointer does not move either.
    assign kill       = rst_i | flush_i;
    assign gnt_o      = kill ? '0 : grant;
    assign conflict_o = kill ? 1'b0 : conflict;

    always_comb begin
        rr_d = rr_q;
        if (conflict_o) begin
            rr_d = (int'(win_idx) == NUM_RD - 1) ? '0 : win_idx + RRW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/vregfile_banked.sv
// Banked physical vector register file with per-bank round-robin read arbitration and
// registered read data. Define VREGFILE_BANKED_BYPASS_EN to forward same-cycle write data.
module vregfile_banked
    import drac_pkg::*;
#(
    parameter  int NUM_RD    = 3,
    parameter  int NUM_WR    = NUM_SIMD_WB,
    parameter  int NUM_BANKS = VRF_NUM_BANKS,
    parameter  int NUM_REGS  = NUM_PHISICAL_VREGISTERS,
    parameter  int DATA_W    = VLEN,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*AW-1:0]     wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [NUM_RD-1:0]        rd_req_i,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD-1:0]        rd_gnt_o,
    output logic [NUM_RD-1:0]        rd_valid_o,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic                     bank_conf_o
);

    localparam int BW = $clog2(NUM_BANKS);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [NUM_RD-1:0] rd_valid_q;
    logic [DATA_W-1:0] rd_data_q [NUM_RD];
    logic [DATA_W-1:0] rd_data_d [NUM_RD];

    logic [NUM_RD-1:0]    bank_gnt      [NUM_BANKS];
    logic [AW-1:0]        bank_win_addr [NUM_BANKS];
    logic [DATA_W-1:0]    bank_rdata    [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_conf;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        vrf_bank_arbiter #(
            .NUM_RD    (NUM_RD),
            .NUM_BANKS (NUM_BANKS),
            .AW        (AW),
            .BANK_IDX  (b)
        ) u_arb (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush_i    (flush_i),
            .req_i      (rd_req_i),
            .addr_i     (rd_addr_i),
            .gnt_o      (bank_gnt[b]),
            .win_addr_o (bank_win_addr[b]),
            .conflict_o (bank_conf[b])
        );
    end

    // Each port maps to exactly one bank, so OR-ing the per-bank grants is collision free.
    always_comb begin
        rd_gnt_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_gnt_o = rd_gnt_o | bank_gnt[b];
        end
    end

    assign bank_conf_o = |bank_conf;

    // One array read per bank at the winning address; granted ports share it.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_rdata[b] = mem_q[bank_win_addr[b]];
`ifdef VREGFILE_BANKED_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == bank_win_addr[b])) begin
                    bank_rdata[b] = wr_data_i[w*DATA_W +: DATA_W];
                end
            end
`endif
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data_d[p] = rd_data_q[p];
            if (rd_gnt_o[p]) begin
                rd_data_d[p] = bank_rdata[rd_addr_i[p*AW +: BW]];
            end
        end
    end

    // Later write ports override earlier ones on an address collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w]) begin
                    mem_q[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q <= '0;
            for (int p = 0; p < NUM_RD; p++) begin
                rd_data_q[p] <= '0;
            end
        end else begin
            rd_valid_q <= rd_gnt_o;
            for (int p = 0; p < NUM_RD; p++) begin
                rd_data_q[p] <= rd_data_d[p];
            end
        end
    end

    assign rd_valid_o = rd_valid_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_out
        assign rd_data_o[p*DATA_W +: DATA_W] = rd_data_q[p];
    end

endmodule
